// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg
//   Shared definitions for the pipeline run controller and the UART debug
//   unit: FSM state encodings, the HALT opcode and command priorities.
//   resolve_cmd() picks the winning command when several pulse at once.
package pipe_ctrl_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_RUN    = 3'd1;
    localparam logic [2:0] ST_STEP   = 3'd2;
    localparam logic [2:0] ST_DRAIN  = 3'd3;
    localparam logic [2:0] ST_HALTED = 3'd4;

    localparam logic [5:0] HALT_OPCODE_DEF = 6'h3f;

    // Higher number wins.
    localparam int CMD_PRIO_STEP  = 0;
    localparam int CMD_PRIO_RUN   = 1;
    localparam int CMD_PRIO_STOP  = 2;
    localparam int CMD_PRIO_CLEAR = 3;

    // Each command's encoding is its priority + 1, so NONE is zero.
    typedef enum logic [2:0] {
        CMD_NONE  = 3'd0,
        CMD_STEP  = 3'd1,
        CMD_RUN   = 3'd2,
        CMD_STOP  = 3'd3,
        CMD_CLEAR = 3'd4
    } cmd_e;

    function automatic cmd_e resolve_cmd(input logic clr, input logic stop,
                                         input logic run, input logic step);
        logic [3:0] req;
        req                 = '0;
        req[CMD_PRIO_CLEAR] = clr;
        req[CMD_PRIO_STOP]  = stop;
        req[CMD_PRIO_RUN]   = run;
        req[CMD_PRIO_STEP]  = step;
        resolve_cmd = CMD_NONE;
        for (int p = 0; p < 4; p++)
            if (req[p]) resolve_cmd = cmd_e'(3'(p + 1));
    endfunction

endpackage

// File: rtl/pipeline_run_controller_if.sv
// pipeline_run_controller_if
//   Debug-side bus of the run controller.
//   master: debug unit / pipeline side (drives commands and hazard inputs)
//   slave : run controller (drives enables, flush, status, cycle count)
interface pipeline_run_controller_if #(
    parameter int NB_OPCODE = 6,
    parameter int NB_CYCLE  = 32
);
    logic                 i_cmd_run;
    logic                 i_cmd_step;
    logic                 i_cmd_stop;
    logic                 i_cmd_clear;
    logic [NB_OPCODE-1:0] i_if_opcode;
    logic                 i_branch_taken;
    logic                 i_load_stall;
    logic                 o_pipe_enable;
    logic                 o_pc_enable;
    logic                 o_flush;
    logic                 o_halted;
    logic                 o_step_done;
    logic [2:0]           o_state;
    logic [NB_CYCLE-1:0]  o_cycle_count;

    modport master (
        output i_cmd_run, i_cmd_step, i_cmd_stop, i_cmd_clear,
        output i_if_opcode, i_branch_taken, i_load_stall,
        input  o_pipe_enable, o_pc_enable, o_flush, o_halted,
        input  o_step_done, o_state, o_cycle_count
    );

    modport slave (
        input  i_cmd_run, i_cmd_step, i_cmd_stop, i_cmd_clear,
        input  i_if_opcode, i_branch_taken, i_load_stall,
        output o_pipe_enable, o_pc_enable, o_flush, o_halted,
        output o_step_done, o_state, o_cycle_count
    );
endinterface

// File: rtl/sat_cycle_counter.sv
// sat_cycle_counter
//   NB_CYCLE-bit up counter that sticks at all-ones. Clear beats increment.
//   i_clock, i_reset (async, active low), i_inc, i_clear -> o_count
module sat_cycle_counter #(
    parameter int NB_CYCLE = 32
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_inc,
    input  logic                i_clear,
    output logic [NB_CYCLE-1:0] o_count
);
    logic [NB_CYCLE-1:0] r_count;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset)
            r_count <= '0;
        else if (i_clear)
            r_count <= '0;
        else if (i_inc && (r_count != '1))
            r_count <= r_count + NB_CYCLE'(1);
    end

    assign o_count = r_count;
endmodule

// File: rtl/pipeline_run_controller.sv
// pipeline_run_controller
//   Sequences the 5-stage MIPS pipeline for the debug flow: run / step /
//   stop / clear commands, HALT detection at IF/ID, drain of the
//   instructions behind HALT, then park in HALTED.
//   Ports: i_clock, i_reset (async, active low), bus (slave modport:
//   commands, IF/ID opcode, branch/stall in; pipe/pc enable, flush,
//   halted, step_done, state, cycle count out).
//   Optional: PIPE_CTRL_BREAKPOINT_EN adds i_bp_valid, i_bp_addr, i_if_pc;
//   a PC match in RUN suppresses that cycle and drops back to IDLE.
module pipeline_run_controller
    import pipe_ctrl_pkg::*;
#(
    parameter int                   NB_OPCODE    = 6,
    parameter logic [NB_OPCODE-1:0] HALT_OPCODE  = HALT_OPCODE_DEF,
    parameter int                   DRAIN_CYCLES = 4,
    parameter int                   NB_CYCLE     = 32,
    parameter int                   NB_PC        = 32
) (
    input  logic             i_clock,
    input  logic             i_reset,
`ifdef PIPE_CTRL_BREAKPOINT_EN
    input  logic             i_bp_valid,
    input  logic [NB_PC-1:0] i_bp_addr,
    input  logic [NB_PC-1:0] i_if_pc,
`endif
    pipeline_run_controller_if.slave bus
);
    localparam int                NB_DRAIN   = $clog2(DRAIN_CYCLES + 1);
    localparam logic [NB_DRAIN-1:0] DRAIN_LOAD = NB_DRAIN'(DRAIN_CYCLES - 1);

    logic [2:0]          r_state, w_next_state;
    logic                r_halt_seen, w_halt_seen_nxt;
    logic [NB_DRAIN-1:0] r_drain_cnt, w_drain_cnt_nxt;
    logic                r_step_done;
    cmd_e                w_cmd;
    logic                w_pipe_en, w_hit_halt, w_bp_hit, w_clear;
    logic [NB_CYCLE-1:0] w_cycle_count;

    assign w_cmd   = resolve_cmd(bus.i_cmd_clear, bus.i_cmd_stop,
                                 bus.i_cmd_run, bus.i_cmd_step);
    assign w_clear = (w_cmd == CMD_CLEAR);

`ifdef PIPE_CTRL_BREAKPOINT_EN
    // Set on the first RUN cycle after a run command so a resume from a
    // breakpoint can execute the instruction sitting at that address.
    logic r_bp_skip;
    assign w_bp_hit = (r_state == ST_RUN) && i_bp_valid &&
                      (i_if_pc == i_bp_addr) && !r_bp_skip;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) r_bp_skip <= 1'b0;
        else          r_bp_skip <= (r_state == ST_IDLE) && (w_next_state == ST_RUN);
    end
`else
    // NB_PC only sizes the breakpoint ports.
    logic [NB_PC-1:0] w_unused_pc;
    assign w_unused_pc = '0;
    assign w_bp_hit    = 1'b0;
`endif

    assign w_pipe_en  = ((r_state == ST_RUN) || (r_state == ST_DRAIN) ||
                         (r_state == ST_STEP)) && !w_bp_hit;
    assign w_hit_halt = w_pipe_en && (bus.i_if_opcode == HALT_OPCODE);

    always_comb begin
        w_next_state    = r_state;
        w_halt_seen_nxt = r_halt_seen;
        w_drain_cnt_nxt = r_drain_cnt;
        // HALT is armed once; the PC then holds it at IF/ID, so hit_halt
        // stays true and must not reload the drain count.
        if (w_hit_halt && !r_halt_seen &&
            ((r_state == ST_RUN) || (r_state == ST_STEP))) begin
            w_halt_seen_nxt = 1'b1;
            w_drain_cnt_nxt = DRAIN_LOAD;
        end
        case (r_state)
            ST_IDLE: begin
                if (w_cmd == CMD_RUN)
                    w_next_state = r_halt_seen ? ST_DRAIN : ST_RUN;
                else if (w_cmd == CMD_STEP)
                    w_next_state = ST_STEP;
            end
            ST_RUN: begin
                if ((w_cmd == CMD_STOP) || w_bp_hit) w_next_state = ST_IDLE;
                else if (w_hit_halt)                 w_next_state = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (w_cmd == CMD_STOP) begin
                    w_next_state = ST_IDLE;
                end else if (r_drain_cnt <= NB_DRAIN'(1)) begin
                    w_next_state    = ST_HALTED;
                    w_drain_cnt_nxt = '0;
                end else begin
                    w_drain_cnt_nxt = r_drain_cnt - NB_DRAIN'(1);
                end
            end
            ST_STEP: begin
                w_next_state = ST_IDLE;
                // Stepping through the drain: the last drain step parks.
                if (r_halt_seen) begin
                    if (r_drain_cnt <= NB_DRAIN'(1)) begin
                        w_next_state    = ST_HALTED;
                        w_drain_cnt_nxt = '0;
                    end else begin
                        w_drain_cnt_nxt = r_drain_cnt - NB_DRAIN'(1);
                    end
                end
            end
            ST_HALTED: ;
            default: w_next_state = ST_IDLE;
        endcase
        if (w_clear) begin
            w_next_state    = ST_IDLE;
            w_halt_seen_nxt = 1'b0;
            w_drain_cnt_nxt = '0;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state     <= ST_IDLE;
            r_halt_seen <= 1'b0;
            r_drain_cnt <= '0;
            r_step_done <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_halt_seen <= w_halt_seen_nxt;
            r_drain_cnt <= w_drain_cnt_nxt;
            r_step_done <= (r_state == ST_STEP);
        end
    end

    sat_cycle_counter #(.NB_CYCLE(NB_CYCLE)) u_cycle_cnt (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_inc   (w_pipe_en),
        .i_clear (w_clear),
        .o_count (w_cycle_count)
    );

    assign bus.o_pipe_enable = w_pipe_en;
    assign bus.o_pc_enable   = w_pipe_en && !bus.i_load_stall && !r_halt_seen && !w_hit_halt;
    assign bus.o_flush       = w_pipe_en && bus.i_branch_taken;
    assign bus.o_halted      = (r_state == ST_HALTED);
    assign bus.o_step_done   = r_step_done;
    assign bus.o_state       = r_state;
    assign bus.o_cycle_count = w_cycle_count;
endmodule

// File: tb/tb_pipeline_run_controller.sv
// tb_pipeline_run_controller
//   Directed test-plan scenarios plus randomized commands/opcodes, checked
//   every cycle against a behavioural model; literal expectations pin the
//   model at key points of the directed scenarios.
module tb_pipeline_run_controller;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    pipeline_run_controller_if #(.NB_OPCODE(6), .NB_CYCLE(32)) bus();

    pipeline_run_controller dut (
        .i_clock (clk),
        .i_reset (rst_n),
        .bus     (bus)
    );

    int n_pass  = 0;
    int n_total = 0;

    // behavioural model: program phase, remaining drain cycles, counts
    int          m_state;
    bit          m_halt;
    int          m_drain;
    logic [31:0] m_count;
    bit          m_sd;

    function automatic void m_reset();
        m_state = 0; m_halt = 0; m_drain = 0; m_count = 0; m_sd = 0;
    endfunction

    function automatic bit m_exec();
        return (m_state == 1) || (m_state == 2) || (m_state == 3);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        else n_pass++;
    endtask

    task automatic compare();
        bit ex, hit;
        ex  = m_exec();
        hit = ex && (bus.i_if_opcode == 6'h3f);
        chk("pipe_enable", 32'(bus.o_pipe_enable), 32'(ex));
        chk("pc_enable",   32'(bus.o_pc_enable),   32'(ex && !bus.i_load_stall && !m_halt && !hit));
        chk("flush",       32'(bus.o_flush),       32'(ex && bus.i_branch_taken));
        chk("halted",      32'(bus.o_halted),      32'(m_state == 4));
        chk("step_done",   32'(bus.o_step_done),   32'(m_sd));
        chk("state",       32'(bus.o_state),       32'(m_state));
        chk("cycle_count", bus.o_cycle_count,      m_count);
    endtask

    function automatic void m_update();
        bit ex, hit, had_halt;
        if (!rst_n) begin m_reset(); return; end
        ex       = m_exec();
        hit      = ex && (bus.i_if_opcode == 6'h3f);
        had_halt = m_halt;
        m_sd     = (m_state == 2);
        if (bus.i_cmd_clear) begin
            m_state = 0; m_halt = 0; m_drain = 0; m_count = 0;
            return;
        end
        if (ex && m_count != 32'hffff_ffff) m_count = m_count + 1;
        if (hit && !m_halt && (m_state == 1 || m_state == 2)) begin
            m_halt = 1; m_drain = 3;
        end
        case (m_state)
            0: if (!bus.i_cmd_stop) begin
                   if (bus.i_cmd_run)       m_state = m_halt ? 3 : 1;
                   else if (bus.i_cmd_step) m_state = 2;
               end
            1: if (bus.i_cmd_stop) m_state = 0; else if (hit) m_state = 3;
            2: begin
                   m_state = 0;
                   if (had_halt) begin
                       m_drain--;
                       if (m_drain <= 0) begin m_drain = 0; m_state = 4; end
                   end
               end
            3: if (bus.i_cmd_stop) m_state = 0;
               else begin
                   m_drain--;
                   if (m_drain <= 0) begin m_drain = 0; m_state = 4; end
               end
            default: ;
        endcase
    endfunction

    task automatic settle(); @(negedge clk); compare(); endtask
    task automatic adv();    @(posedge clk); m_update(); #1; endtask
    task automatic tick();   settle(); adv(); endtask

    task automatic pulse(input bit clr, input bit stop, input bit run, input bit step);
        bus.i_cmd_clear = clr; bus.i_cmd_stop = stop; bus.i_cmd_run = run; bus.i_cmd_step = step;
        tick();
        bus.i_cmd_clear = 0; bus.i_cmd_stop = 0; bus.i_cmd_run = 0; bus.i_cmd_step = 0;
    endtask

    initial begin
        int n;
        bus.i_cmd_run = 0; bus.i_cmd_step = 0; bus.i_cmd_stop = 0; bus.i_cmd_clear = 0;
        bus.i_if_opcode = 6'h00; bus.i_branch_taken = 0; bus.i_load_stall = 0;
        m_reset();
        #2 rst_n = 0;
        #1;
        chk("rst_state", 32'(bus.o_state), 0);
        chk("rst_count", bus.o_cycle_count, 0);
        chk("rst_pipe_en", 32'(bus.o_pipe_enable), 0);
        tick(); tick();
        rst_n = 1;

        // run into HALT: 0x00, 0x08, 0x3f then drain
        pulse(0, 0, 1, 0);
        bus.i_if_opcode = 6'h00; tick();
        bus.i_if_opcode = 6'h08; tick();
        bus.i_if_opcode = 6'h3f; settle();
        chk("halt_pc_en", 32'(bus.o_pc_enable), 0);
        chk("halt_pipe_en", 32'(bus.o_pipe_enable), 1);
        adv();
        repeat (3) tick();
        settle();
        chk("halted", 32'(bus.o_halted), 1);
        chk("halt_count", bus.o_cycle_count, 6);
        adv();
        pulse(0, 0, 1, 0);
        pulse(0, 0, 0, 1);
        settle();
        chk("halted_ignores", 32'(bus.o_state), 4);
        chk("halted_frozen", bus.o_cycle_count, 6);
        adv();
        pulse(1, 0, 0, 0);
        settle();
        chk("clr_state", 32'(bus.o_state), 0);
        chk("clr_count", bus.o_cycle_count, 0);
        chk("clr_halted", 32'(bus.o_halted), 0);
        adv();

        // three single steps
        bus.i_if_opcode = 6'h00;
        for (int i = 0; i < 3; i++) begin
            pulse(0, 0, 0, 1);
            settle();
            chk("step_en", 32'(bus.o_pipe_enable), 1);
            adv();
            settle();
            chk("step_done", 32'(bus.o_step_done), 1);
            chk("step_off", 32'(bus.o_pipe_enable), 0);
            adv();
        end
        settle();
        chk("step_count", bus.o_cycle_count, 3);
        adv();

        // load stall and branch flush while running
        pulse(1, 0, 0, 0);
        pulse(0, 0, 1, 0);
        bus.i_load_stall = 1;
        for (int i = 0; i < 2; i++) begin
            settle();
            chk("stall_pipe_en", 32'(bus.o_pipe_enable), 1);
            chk("stall_pc_en", 32'(bus.o_pc_enable), 0);
            adv();
        end
        bus.i_load_stall = 0; bus.i_branch_taken = 1;
        settle();
        chk("flush", 32'(bus.o_flush), 1);
        adv();
        bus.i_branch_taken = 0;
        pulse(0, 1, 0, 0);

        // stop in DRAIN with two drain cycles left, then resume
        pulse(1, 0, 0, 0);
        pulse(0, 0, 1, 0);
        bus.i_if_opcode = 6'h3f;
        tick(); tick();
        bus.i_cmd_stop = 1;
        settle();
        chk("drain_state", 32'(bus.o_state), 3);
        adv();
        bus.i_cmd_stop = 0;
        pulse(0, 0, 1, 0);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            settle();
            if (bus.o_halted) break;
            if (bus.o_pipe_enable) n++;
            adv();
        end
        chk("resume_halted", 32'(bus.o_halted), 1);
        chk("resume_cycles", 32'(n), 2);
        adv();

        // clear+stop+run together: clear wins (in HALTED and in IDLE)
        pulse(1, 1, 1, 0);
        settle();
        chk("clr_win_halted", 32'(bus.o_state), 0);
        adv();
        pulse(1, 1, 1, 0);
        settle();
        chk("clr_win_idle", 32'(bus.o_state), 0);
        adv();

        // reset in the middle of DRAIN
        bus.i_if_opcode = 6'h00;
        pulse(0, 0, 1, 0);
        bus.i_if_opcode = 6'h3f;
        tick(); tick();
        rst_n = 0;
        #1;
        chk("mid_rst_state", 32'(bus.o_state), 0);
        chk("mid_rst_count", bus.o_cycle_count, 0);
        m_reset();
        tick();
        rst_n = 1;
        bus.i_if_opcode = 6'h00;
        pulse(0, 0, 1, 0);
        settle();
        chk("post_rst_run", 32'(bus.o_state), 1);
        adv();
        pulse(0, 1, 0, 0);

        // randomized traffic
        for (int i = 0; i < 2500; i++) begin
            bus.i_cmd_run      = ($urandom_range(0, 11) == 0);
            bus.i_cmd_step     = ($urandom_range(0, 11) == 0);
            bus.i_cmd_stop     = ($urandom_range(0, 29) == 0);
            bus.i_cmd_clear    = ($urandom_range(0, 59) == 0);
            bus.i_if_opcode    = ($urandom_range(0, 9) == 0) ? 6'h3f : 6'($urandom_range(0, 62));
            bus.i_load_stall   = ($urandom_range(0, 3) == 0);
            bus.i_branch_taken = ($urandom_range(0, 4) == 0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/pipeline_run_controller.md
Name: pipeline_run_controller

Overview:
Sequences execution of the 5-stage MIPS pipeline for the debug flow. It accepts run, step, stop and clear commands and drives the global pipeline enable, the PC enable and the IF/ID flush. These outputs also feed the control unit's enable and its flush/reset input. It detects the HALT opcode at IF/ID, drains in-flight instructions, then parks in HALTED and counts executed cycles.

Parameters:
NB_OPCODE, 6, opcode width
HALT_OPCODE, 6'h3f, opcode that ends the program
DRAIN_CYCLES, 4, pipeline cycles still needed to retire instructions behind HALT
NB_CYCLE, 32, cycle counter width
NB_PC, 32, PC width (used only by the optional feature)

Ports:
i_clock  in  1  clock
i_reset  in  1  asynchronous, active-low reset
i_cmd_run  in  1  start continuous execution (1-cycle pulse)
i_cmd_step  in  1  execute exactly one pipeline cycle (pulse)
i_cmd_stop  in  1  pause (pulse)
i_cmd_clear  in  1  leave HALTED; clear counter and halt flag (pulse)
i_if_opcode  in  NB_OPCODE  opcode of the instruction in IF/ID
i_branch_taken  in  1  branch resolved taken
i_load_stall  in  1  load-use hazard stall request
o_pipe_enable  out  1  enable for pipeline registers and the control unit
o_pc_enable  out  1  PC update enable
o_flush  out  1  IF/ID flush, also drives the control unit flush
o_halted  out  1  program finished
o_step_done  out  1  1-cycle pulse after a step completes
o_state  out  3  current FSM state
o_cycle_count  out  NB_CYCLE  cycles with o_pipe_enable=1

Behaviour:
- Reset (i_reset=0, async) state and outputs:
  - state=IDLE; halt_seen=0; drain_cnt=0.
  - cycle_count=0; o_step_done=0.
  - All combinational outputs are 0.
- States and encoding: IDLE=0, RUN=1, STEP=2, DRAIN=3, HALTED=4.
- Command priority when several are asserted in one cycle: clear > stop > run > step.
- o_pipe_enable:
  - 1 in RUN and DRAIN.
  - 1 in STEP for exactly its single cycle.
  - 0 in IDLE and HALTED.
- o_pc_enable = o_pipe_enable & ~i_load_stall & ~halt_seen & ~hit_halt.
  - hit_halt = (i_if_opcode==HALT_OPCODE) while enabled.
  - The PC never advances past HALT.
- o_flush = o_pipe_enable & i_branch_taken. It is combinational, with no latency.
- IDLE:
  - run -> RUN.
  - step -> STEP.
  - clear -> IDLE, clearing the counter and halt_seen.
- RUN:
  - stop -> IDLE.
  - hit_halt -> DRAIN: halt_seen<=1, drain_cnt<=DRAIN_CYCLES-1.
- DRAIN:
  - drain_cnt decrements each cycle; at 0 -> HALTED.
  - stop -> IDLE, keeping halt_seen and drain_cnt.
  - A later run resumes in DRAIN with the remaining count.
- STEP:
  - One enabled cycle, then IDLE with o_step_done=1 on the next cycle.
  - If hit_halt occurs here, set halt_seen and load drain_cnt.
  - If halt_seen is already set, the step decrements drain_cnt; when it reaches 0 the next state is HALTED instead of IDLE, and o_step_done still pulses.
  - A step during a load stall still counts as a step (PC held).
- HALTED:
  - o_halted=1 and outputs are frozen.
  - run, step and stop are ignored.
  - clear -> IDLE, with halt_seen=0 and cycle_count=0.
- Cycle counter:
  - Increments when o_pipe_enable=1 and saturates at all-ones.
  - Clear wins over increment in the same cycle.
- Reset mid-DRAIN or mid-STEP discards all progress and returns to IDLE.

Optional Feature:
PIPE_CTRL_BREAKPOINT_EN
- When defined, adds ports i_bp_valid (1), i_bp_addr (NB_PC) and i_if_pc (NB_PC).
- In RUN, if i_bp_valid and i_if_pc==i_bp_addr:
  - that cycle has o_pipe_enable=0 and the state goes to IDLE;
  - the instruction at the breakpoint is not executed.
- The next run ignores a match for one cycle so execution can proceed past the breakpoint.
- When undefined, the ports do not exist and behaviour is as above.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - state encodings (IDLE..HALTED);
  - HALT_OPCODE;
  - command priority constants, shared with the UART debug unit.
- One natural sub-module: sat_cycle_counter, an NB_CYCLE saturating counter with inc and clear inputs.

Test Plan:
- Reset, then run; opcode stream 0x00,0x08,0x3f -> o_pc_enable drops in the 0x3f cycle; 4 enabled cycles later o_halted=1, o_cycle_count=6.
- Three step pulses from IDLE -> three single-cycle o_pipe_enable pulses, three o_step_done pulses, o_cycle_count=3.
- Run, then i_load_stall=1 for 2 cycles -> o_pipe_enable=1 and o_pc_enable=0 for both cycles; i_branch_taken=1 -> o_flush=1 in the same cycle.
- Stop pulse during DRAIN with drain_cnt=2, then run -> exactly 2 more enabled cycles, then HALTED.
- In HALTED, run and step are ignored; clear -> IDLE, o_cycle_count=0, o_halted=0; clear+stop+run in the same cycle -> clear wins.
- With PIPE_CTRL_BREAKPOINT_EN: i_bp_addr=0x10 and i_if_pc reaches 0x10 -> IDLE with o_pipe_enable=0; the next run proceeds past 0x10.
